// File: rtl/mem_axi_pkg.sv
// Shared definitions for the mem-side AXI4-Lite master.
//   - Access size encodings carried on the simple memory interface.
//   - AXI response codes seen on the B and R channels.
//   - Controller state enumeration.
//   - Helpers that classify an access request and a bus response.
package mem_axi_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WADDR,
    WRESP,
    RADDR,
    RDATA,
    FIN
  } state_e;

  // An access is rejected before touching the bus when its size is the
  // reserved code or its address is not a multiple of its width.
  function automatic logic isBadAccess(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      SZ_WORD: return off != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  // Anything other than OKAY is treated as a failed transfer.
  function automatic logic respBad(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/mem_axi_lane.sv
// Byte-lane steering between the right-justified memory interface and the
// 32-bit AXI data bus. Purely combinational.
// Ports:
//   size_i  - access size code
//   off_i   - byte offset within the 32-bit word (addr[1:0])
//   din_i   - right-justified write data
//   rdata_i - raw AXI read data
//   wstrb_o - AXI write strobes for the addressed lanes
//   wdata_o - write data replicated across all lanes
//   dout_o  - addressed lanes of rdata_i, right-justified and zero-extended
module mem_axi_lane
  import mem_axi_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] din_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] dout_o
);

  logic [15:0] rdShifted;

  // Bring the addressed lane down to bit 0; only the low half is ever used
  // because sub-word accesses are at most 16 bits wide.
  assign rdShifted = 16'(rdata_i >> {off_i, 3'b000});

  // Replicating the write data means the slave finds the right bytes on
  // whichever lanes the strobe enables, without a separate data shifter.
  always_comb begin
    wstrb_o = 4'b0000;
    wdata_o = 32'h0;
    dout_o  = 32'h0;
    case (size_i)
      SZ_BYTE: begin
        wstrb_o = 4'b0001 << off_i;
        wdata_o = {4{din_i[7:0]}};
        dout_o  = {24'h0, rdShifted[7:0]};
      end
      SZ_HALF: begin
        wstrb_o = 4'b0011 << off_i;
        wdata_o = {2{din_i[15:0]}};
        dout_o  = {16'h0, rdShifted};
      end
      SZ_WORD: begin
        wstrb_o = 4'b1111;
        wdata_o = din_i;
        dout_o  = rdata_i;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/mem_sram_axi_master.sv
// Turns single requests on the simple memory interface into AXI4-Lite
// transactions, one outstanding access at a time.
// Parameters: ADDR_W (address width), AXI_PROT (constant awprot/arprot).
// Ports:
//   clk, rst_n                - clock, synchronous active-low reset
//   en, wen, addr, size, din  - request (sampled only while idle)
//   done, err, dout           - one-cycle completion pulse, error flag, read data
//   m_aw*, m_w*, m_b*         - AXI write address / data / response channels
//   m_ar*, m_r*               - AXI read address / data channels
// Optional build macro MEM_SRAM_AXI_RESP_CHK_EN: when defined, a non-OKAY
// bresp/rresp raises err alongside done; otherwise responses are ignored.
module mem_sram_axi_master
  import mem_axi_pkg::*;
#(
  parameter int          ADDR_W   = 32,
  parameter logic [2:0]  AXI_PROT = 3'b000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              wen,
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        size,
  input  logic [31:0]       din,
  output logic              done,
  output logic              err,
  output logic [31:0]       dout,
  output logic [ADDR_W-1:0] m_awaddr,
  output logic [2:0]        m_awprot,
  output logic              m_awvalid,
  input  logic              m_awready,
  output logic [31:0]       m_wdata,
  output logic [3:0]        m_wstrb,
  output logic              m_wvalid,
  input  logic              m_wready,
  input  logic [1:0]        m_bresp,
  input  logic              m_bvalid,
  output logic              m_bready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [2:0]        m_arprot,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [31:0]       m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rvalid,
  output logic              m_rready
);

  state_e            state_q;
  logic [1:0]        size_q;
  logic [1:0]        off_q;
  logic              done_q;
  logic              err_q;
  logic [31:0]       dout_q;
  logic [ADDR_W-1:0] awaddr_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic              awValid_q;
  logic              wValid_q;
  logic              bReady_q;
  logic              arValid_q;
  logic              rReady_q;

  logic [ADDR_W-1:0] alignedAddr;
  logic [1:0]        laneSize;
  logic [1:0]        laneOff;
  logic [3:0]        laneWstrb;
  logic [31:0]       laneWdata;
  logic [31:0]       laneDout;
  logic              awDone;
  logic              wDone;
  logic              bErr;
  logic              rErr;

  assign alignedAddr = {addr[ADDR_W-1:2], 2'b00};

  // While idle the lane logic works on the live request so write lanes can
  // be registered on acceptance; afterwards it uses the latched request so
  // read data is steered by the access that issued it.
  assign laneSize = (state_q == IDLE) ? size : size_q;
  assign laneOff  = (state_q == IDLE) ? addr[1:0] : off_q;

  mem_axi_lane u_lane (
    .size_i  (laneSize),
    .off_i   (laneOff),
    .din_i   (din),
    .rdata_i (m_rdata),
    .wstrb_o (laneWstrb),
    .wdata_o (laneWdata),
    .dout_o  (laneDout)
  );

`ifdef MEM_SRAM_AXI_RESP_CHK_EN
  assign bErr = respBad(m_bresp);
  assign rErr = respBad(m_rresp);
`else
  logic unusedResp;
  assign unusedResp = ^{m_bresp, m_rresp};
  assign bErr = 1'b0;
  assign rErr = 1'b0;
`endif

  // A write channel counts as finished once its valid has already dropped
  // or it is handshaking in this cycle, so AW and W may complete in any order.
  assign awDone = !awValid_q || m_awready;
  assign wDone  = !wValid_q  || m_wready;

  // Single controller: every interface output is a register updated here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      size_q    <= SZ_BYTE;
      off_q     <= 2'b00;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      dout_q    <= 32'h0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= 32'h0;
      wstrb_q   <= 4'b0000;
      awValid_q <= 1'b0;
      wValid_q  <= 1'b0;
      bReady_q  <= 1'b0;
      arValid_q <= 1'b0;
      rReady_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en) begin
            size_q <= size;
            off_q  <= addr[1:0];
            if (isBadAccess(size, addr[1:0])) begin
              done_q  <= 1'b1;
              err_q   <= 1'b1;
              state_q <= FIN;
            end else if (wen) begin
              awaddr_q  <= alignedAddr;
              wdata_q   <= laneWdata;
              wstrb_q   <= laneWstrb;
              awValid_q <= 1'b1;
              wValid_q  <= 1'b1;
              state_q   <= WADDR;
            end else begin
              araddr_q  <= alignedAddr;
              arValid_q <= 1'b1;
              state_q   <= RADDR;
            end
          end
        end
        WADDR: begin
          if (awDone && wDone) begin
            awValid_q <= 1'b0;
            wValid_q  <= 1'b0;
            bReady_q  <= 1'b1;
            state_q   <= WRESP;
          end else begin
            if (m_awready) awValid_q <= 1'b0;
            if (m_wready)  wValid_q  <= 1'b0;
          end
        end
        WRESP: begin
          if (m_bvalid) begin
            bReady_q <= 1'b0;
            done_q   <= 1'b1;
            err_q    <= bErr;
            state_q  <= FIN;
          end
        end
        RADDR: begin
          if (m_arready) begin
            arValid_q <= 1'b0;
            rReady_q  <= 1'b1;
            state_q   <= RDATA;
          end
        end
        RDATA: begin
          if (m_rvalid) begin
            rReady_q <= 1'b0;
            dout_q   <= laneDout;
            done_q   <= 1'b1;
            err_q    <= rErr;
            state_q  <= FIN;
          end
        end
        FIN: begin
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign done      = done_q;
  assign err       = err_q;
  assign dout      = dout_q;
  assign m_awaddr  = awaddr_q;
  assign m_awprot  = AXI_PROT;
  assign m_awvalid = awValid_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = wstrb_q;
  assign m_wvalid  = wValid_q;
  assign m_bready  = bReady_q;
  assign m_araddr  = araddr_q;
  assign m_arprot  = AXI_PROT;
  assign m_arvalid = arValid_q;
  assign m_rready  = rReady_q;

endmodule

// File: tb/tb_mem_sram_axi_master.sv
// Self-checking bench for mem_sram_axi_master: a behavioural AXI4-Lite SRAM
// slave with per-channel ready/response delays, a byte-addressed reference
// memory, directed scenarios and a randomized access sequence.
module tb_mem_sram_axi_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        wen = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [1:0]  size = 2'd0;
  logic [31:0] din = 32'h0;
  logic        done, err;
  logic [31:0] dout;
  logic [31:0] m_awaddr, m_araddr, m_wdata, m_rdata;
  logic [2:0]  m_awprot, m_arprot;
  logic [3:0]  m_wstrb;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [1:0]  m_bresp, m_rresp;

  int compared = 0;
  int mismatched = 0;

  int awDly = 0, wDly = 0, bDly = 0, arDly = 0, rDly = 0;
  logic [1:0] bRespCfg = 2'b00, rRespCfg = 2'b00;

  logic [31:0] slaveMem [int unsigned];
  logic [7:0]  refMem [int unsigned];

  int awHs, wHs, arHs, awHigh, wHigh, arHigh;
  int protoErr = 0;
  logic [31:0] capAwaddr, capWdata, capAraddr;
  logic [3:0]  capWstrb;

  mem_sram_axi_master dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .wen       (wen),
    .addr      (addr),
    .size      (size),
    .din       (din),
    .done      (done),
    .err       (err),
    .dout      (dout),
    .m_awaddr  (m_awaddr),
    .m_awprot  (m_awprot),
    .m_awvalid (m_awvalid),
    .m_awready (m_awready),
    .m_wdata   (m_wdata),
    .m_wstrb   (m_wstrb),
    .m_wvalid  (m_wvalid),
    .m_wready  (m_wready),
    .m_bresp   (m_bresp),
    .m_bvalid  (m_bvalid),
    .m_bready  (m_bready),
    .m_araddr  (m_araddr),
    .m_arprot  (m_arprot),
    .m_arvalid (m_arvalid),
    .m_arready (m_arready),
    .m_rdata   (m_rdata),
    .m_rresp   (m_rresp),
    .m_rvalid  (m_rvalid),
    .m_rready  (m_rready)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Slave model: works on falling edges. It first retires the handshakes
  // that happened on the preceding rising edge (from a snapshot taken one
  // falling edge earlier), checks that pending valids were not withdrawn or
  // changed, then raises readies/responses after the configured delays.
  initial begin
    logic pAwV, pAwR, pWV, pWR, pBV, pBR, pArV, pArR, pRV, pRR;
    logic [31:0] pAwaddr, pWdata, pAraddr;
    logic [3:0]  pWstrb;
    logic aGot, wGot, bPend, rPend;
    int awCnt, wCnt, arCnt, bCnt, rCnt;
    {pAwV, pAwR, pWV, pWR, pBV, pBR, pArV, pArR, pRV, pRR} = '0;
    {aGot, wGot, bPend, rPend} = '0;
    {awCnt, wCnt, arCnt, bCnt, rCnt} = '0;
    pAwaddr = '0; pWdata = '0; pAraddr = '0; pWstrb = '0;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
    m_arready = 0; m_rvalid = 0; m_rresp = 0; m_rdata = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0; m_rvalid = 0;
        {pAwV, pAwR, pWV, pWR, pBV, pBR, pArV, pArR, pRV, pRR} = '0;
        {aGot, wGot, bPend, rPend} = '0;
        {awCnt, wCnt, arCnt, bCnt, rCnt} = '0;
        continue;
      end
      if (pAwV && pAwR) begin awHs++; capAwaddr = pAwaddr; aGot = 1; end
      if (pWV && pWR) begin wHs++; capWdata = pWdata; capWstrb = pWstrb; wGot = 1; end
      if (pBV && pBR) m_bvalid = 0;
      if (pArV && pArR) begin arHs++; capAraddr = pAraddr; rPend = 1; rCnt = 0; end
      if (pRV && pRR) m_rvalid = 0;
      if (pAwV && !pAwR && (m_awvalid !== 1'b1 || m_awaddr !== pAwaddr)) protoErr++;
      if (pWV && !pWR && (m_wvalid !== 1'b1 || m_wdata !== pWdata || m_wstrb !== pWstrb)) protoErr++;
      if (pArV && !pArR && (m_arvalid !== 1'b1 || m_araddr !== pAraddr)) protoErr++;
      if (aGot && wGot) begin
        logic [31:0] word;
        word = slaveMem.exists(capAwaddr) ? slaveMem[capAwaddr] : 32'h0;
        for (int i = 0; i < 4; i++)
          if (capWstrb[i]) word[8*i +: 8] = capWdata[8*i +: 8];
        slaveMem[capAwaddr] = word;
        aGot = 0; wGot = 0; bPend = 1; bCnt = 0;
      end
      if (m_awvalid) begin
        awHigh++;
        if (awCnt >= awDly) m_awready = 1; else begin m_awready = 0; awCnt++; end
      end else begin m_awready = 0; awCnt = 0; end
      if (m_wvalid) begin
        wHigh++;
        if (wCnt >= wDly) m_wready = 1; else begin m_wready = 0; wCnt++; end
      end else begin m_wready = 0; wCnt = 0; end
      if (m_arvalid) begin
        arHigh++;
        if (arCnt >= arDly) m_arready = 1; else begin m_arready = 0; arCnt++; end
      end else begin m_arready = 0; arCnt = 0; end
      if (bPend) begin
        if (bCnt >= bDly) begin m_bvalid = 1; m_bresp = bRespCfg; bPend = 0; end
        else bCnt++;
      end
      if (rPend) begin
        if (rCnt >= rDly) begin
          m_rvalid = 1; m_rresp = rRespCfg;
          m_rdata = slaveMem.exists(capAraddr) ? slaveMem[capAraddr] : 32'h0;
          rPend = 0;
        end else rCnt++;
      end
      pAwV = m_awvalid; pAwR = m_awready; pAwaddr = m_awaddr;
      pWV = m_wvalid; pWR = m_wready; pWdata = m_wdata; pWstrb = m_wstrb;
      pBV = m_bvalid; pBR = m_bready;
      pArV = m_arvalid; pArR = m_arready; pAraddr = m_araddr;
      pRV = m_rvalid; pRR = m_rready;
    end
  end

  // Load one word into both the slave array and the byte reference model.
  task automatic preload(input int unsigned wa, input logic [31:0] v);
    slaveMem[wa] = v;
    for (int i = 0; i < 4; i++) refMem[wa + i] = v[8*i +: 8];
  endtask

  // Issue one request and observe its completion. Inputs are scrambled
  // right after acceptance so only the latched request can matter.
  task automatic doAccess(input logic w, input logic [31:0] a, input logic [1:0] sz,
                          input logic [31:0] d, output int lat, output logic gotErr,
                          output logic [31:0] gotDout, output logic doneAfter);
    awHs = 0; wHs = 0; arHs = 0; awHigh = 0; wHigh = 0; arHigh = 0;
    lat = -1; gotErr = 1'bx; gotDout = 'x; doneAfter = 1'bx;
    @(negedge clk);
    en = 1; wen = w; addr = a; size = sz; din = d;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (k == 1) begin
        en = 0; wen = 1'($urandom); addr = $urandom; size = 2'($urandom); din = $urandom;
      end
      if (done) begin lat = k; gotErr = err; gotDout = dout; break; end
    end
    if (lat > 0) begin @(negedge clk); doneAfter = done; end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    compared++;
    if ({done, err, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready} !== 7'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_ctrl: got %b required 0000000",
               {done, err, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready});
    end
    compared++;
    if ({dout, m_awaddr, m_araddr, m_wdata, m_wstrb} !== 132'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_data: dout=%h awaddr=%h araddr=%h wdata=%h wstrb=%h required all zero",
               dout, m_awaddr, m_araddr, m_wdata, m_wstrb);
    end
    rst_n = 1;
  endtask

  task automatic test_word_write();
    int lat; logic e, da; logic [31:0] q;
    awDly = 0; wDly = 0; bDly = 0; bRespCfg = 2'b00;
    doAccess(1'b1, 32'h100, 2'd2, 32'hDEADBEEF, lat, e, q, da);
    compared++; if (lat !== 3) begin mismatched++; $display("[TB] FAIL word_write latency: got %0d required 3", lat); end
    compared++; if (e !== 1'b0) begin mismatched++; $display("[TB] FAIL word_write err: got %b required 0", e); end
    compared++; if (capAwaddr !== 32'h100) begin mismatched++; $display("[TB] FAIL word_write awaddr: got %h required 00000100", capAwaddr); end
    compared++; if (capWstrb !== 4'hF) begin mismatched++; $display("[TB] FAIL word_write wstrb: got %h required f", capWstrb); end
    compared++; if (capWdata !== 32'hDEADBEEF) begin mismatched++; $display("[TB] FAIL word_write wdata: got %h required deadbeef", capWdata); end
    compared++; if (da !== 1'b0) begin mismatched++; $display("[TB] FAIL word_write done_pulse: got %b required 0 one cycle later", da); end
  endtask

  task automatic test_byte_write();
    int lat; logic e, da; logic [31:0] q;
    doAccess(1'b1, 32'h103, 2'd0, 32'h0000005A, lat, e, q, da);
    compared++; if (capWstrb !== 4'b1000) begin mismatched++; $display("[TB] FAIL byte_write wstrb: got %b required 1000", capWstrb); end
    compared++; if (capWdata !== 32'h5A5A5A5A) begin mismatched++; $display("[TB] FAIL byte_write wdata: got %h required 5a5a5a5a", capWdata); end
    compared++; if (capAwaddr !== 32'h100) begin mismatched++; $display("[TB] FAIL byte_write awaddr: got %h required 00000100", capAwaddr); end
    compared++; if (lat !== 3) begin mismatched++; $display("[TB] FAIL byte_write latency: got %0d required 3", lat); end
  endtask

  task automatic test_half_read();
    int lat; logic e, da; logic [31:0] q;
    preload(32'h200, 32'h1234ABCD);
    awDly = 0; arDly = 0; rDly = 0; rRespCfg = 2'b00;
    doAccess(1'b0, 32'h202, 2'd1, 32'h0, lat, e, q, da);
    compared++; if (q !== 32'h00001234) begin mismatched++; $display("[TB] FAIL half_read dout: got %h required 00001234", q); end
    compared++; if (lat !== 3) begin mismatched++; $display("[TB] FAIL half_read latency: got %0d required 3", lat); end
    compared++; if (capAraddr !== 32'h200) begin mismatched++; $display("[TB] FAIL half_read araddr: got %h required 00000200", capAraddr); end
    compared++; if (da !== 1'b0) begin mismatched++; $display("[TB] FAIL half_read done_pulse: got %b required 0", da); end
    compared++; if (dout !== 32'h00001234) begin mismatched++; $display("[TB] FAIL half_read dout_hold: got %h required 00001234", dout); end
  endtask

  task automatic test_backpressure();
    int lat; logic e, da; logic [31:0] q;
    awDly = 4; wDly = 0; bDly = 2;
    doAccess(1'b1, 32'h300, 2'd2, 32'hCAFEF00D, lat, e, q, da);
    compared++; if (awHigh !== 5) begin mismatched++; $display("[TB] FAIL backpressure awvalid_cycles: got %0d required 5", awHigh); end
    compared++; if (wHigh !== 1) begin mismatched++; $display("[TB] FAIL backpressure wvalid_cycles: got %0d required 1", wHigh); end
    compared++; if (lat !== 9) begin mismatched++; $display("[TB] FAIL backpressure latency: got %0d required 9", lat); end
    compared++; if (capWdata !== 32'hCAFEF00D) begin mismatched++; $display("[TB] FAIL backpressure wdata: got %h required cafef00d", capWdata); end
    compared++; if (protoErr !== 0) begin mismatched++; $display("[TB] FAIL backpressure stability: got %0d violations required 0", protoErr); end
    awDly = 0; bDly = 0;
  endtask

  task automatic test_misaligned();
    int lat; logic e, da; logic [31:0] q;
    logic        w  [3] = '{1'b1, 1'b0, 1'b0};
    logic [31:0] a  [3] = '{32'h101, 32'h100, 32'h201};
    logic [1:0]  sz [3] = '{2'd2, 2'd3, 2'd1};
    for (int i = 0; i < 3; i++) begin
      doAccess(w[i], a[i], sz[i], 32'h11223344, lat, e, q, da);
      compared++; if (lat !== 1) begin mismatched++; $display("[TB] FAIL misaligned%0d latency: got %0d required 1", i, lat); end
      compared++; if (e !== 1'b1) begin mismatched++; $display("[TB] FAIL misaligned%0d err: got %b required 1", i, e); end
      compared++; if (awHigh + wHigh + arHigh !== 0) begin mismatched++; $display("[TB] FAIL misaligned%0d bus_activity: got %0d valid cycles required 0", i, awHigh + wHigh + arHigh); end
    end
  endtask

  task automatic test_resp_err();
    int lat; logic e, da; logic [31:0] q;
    logic expE;
`ifdef MEM_SRAM_AXI_RESP_CHK_EN
    expE = 1'b1;
`else
    expE = 1'b0;
`endif
    preload(32'h200, 32'h1234ABCD);
    rRespCfg = 2'b10;
    doAccess(1'b0, 32'h200, 2'd2, 32'h0, lat, e, q, da);
    compared++; if (e !== expE) begin mismatched++; $display("[TB] FAIL resp_read err: got %b required %b", e, expE); end
    compared++; if (q !== 32'h1234ABCD) begin mismatched++; $display("[TB] FAIL resp_read dout: got %h required 1234abcd", q); end
    bRespCfg = 2'b11;
    doAccess(1'b1, 32'h204, 2'd2, 32'h55AA55AA, lat, e, q, da);
    compared++; if (e !== expE) begin mismatched++; $display("[TB] FAIL resp_write err: got %b required %b", e, expE); end
    rRespCfg = 2'b00; bRespCfg = 2'b00;
  endtask

  task automatic test_reset_mid();
    logic sawDone;
    bDly = 20;
    @(negedge clk);
    en = 1; wen = 1; addr = 32'h100; size = 2'd2; din = 32'h0BADCAFE;
    @(negedge clk);
    en = 0;
    @(negedge clk);
    compared++; if (m_bready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_mid in_wresp: bready got %b required 1", m_bready); end
    rst_n = 0;
    @(negedge clk);
    compared++;
    if ({done, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready} !== 6'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_mid outputs: got %b required 000000",
               {done, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready});
    end
    compared++; if (dout !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_mid dout: got %h required 0", dout); end
    @(negedge clk);
    rst_n = 1;
    sawDone = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (done) sawDone = 1'b1;
    end
    compared++; if (sawDone !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_mid no_done: got done=1 required none"); end
    bDly = 0;
  endtask

  // Random accesses checked against a byte-addressed memory model: strobes
  // and write data follow from which bytes the access covers, read data is
  // assembled from the model, and latency from the configured slave delays.
  task automatic test_random();
    int lat, expLat, n;
    logic e, da, w, misal, expErr;
    logic [31:0] q, a, d, expWdata, expDout;
    logic [1:0] sz;
    logic [3:0] expStrb;
    for (int unsigned wa = 0; wa < 1024; wa += 4) preload(wa, $urandom);
    for (int t = 0; t < 60; t++) begin
      w = 1'($urandom); sz = 2'($urandom_range(0, 3)); d = $urandom;
      a = $urandom_range(0, 1023);
      n = 1 << sz;
      if (sz != 2'd3 && $urandom_range(0, 3) != 0) a = a - (a % n);
      awDly = $urandom_range(0, 3); wDly = $urandom_range(0, 3); bDly = $urandom_range(0, 3);
      arDly = $urandom_range(0, 3); rDly = $urandom_range(0, 3);
      bRespCfg = 2'($urandom); rRespCfg = 2'($urandom);
      misal = (sz == 2'd3) || ((a % n) != 0);
      expLat = misal ? 1 : w ? 3 + ((awDly > wDly) ? awDly : wDly) + bDly : 3 + arDly + rDly;
      expErr = misal;
`ifdef MEM_SRAM_AXI_RESP_CHK_EN
      if (!misal) expErr = w ? (bRespCfg != 2'b00) : (rRespCfg != 2'b00);
`endif
      expStrb = 4'b0; expWdata = 32'h0; expDout = 32'h0;
      if (!misal) begin
        for (int i = 0; i < n; i++) begin
          expStrb[(a % 4) + i] = 1'b1;
          expDout[8*i +: 8] = refMem[a + i];
        end
        for (int j = 0; j < 4; j++) expWdata[8*j +: 8] = d[8*(j % n) +: 8];
      end
      doAccess(w, a, sz, d, lat, e, q, da);
      compared++; if (lat !== expLat) begin mismatched++; $display("[TB] FAIL rand%0d latency: got %0d required %0d", t, lat, expLat); end
      compared++; if (e !== expErr) begin mismatched++; $display("[TB] FAIL rand%0d err: got %b required %b", t, e, expErr); end
      compared++; if (da !== 1'b0) begin mismatched++; $display("[TB] FAIL rand%0d done_pulse: got %b required 0", t, da); end
      if (misal) begin
        compared++; if (awHigh + wHigh + arHigh !== 0) begin mismatched++; $display("[TB] FAIL rand%0d bus_activity: got %0d required 0", t, awHigh + wHigh + arHigh); end
      end else if (w) begin
        compared++; if (capAwaddr !== (a & ~32'h3)) begin mismatched++; $display("[TB] FAIL rand%0d awaddr: got %h required %h", t, capAwaddr, a & ~32'h3); end
        compared++; if (capWstrb !== expStrb) begin mismatched++; $display("[TB] FAIL rand%0d wstrb: got %b required %b", t, capWstrb, expStrb); end
        compared++; if (capWdata !== expWdata) begin mismatched++; $display("[TB] FAIL rand%0d wdata: got %h required %h", t, capWdata, expWdata); end
        for (int i = 0; i < n; i++) refMem[a + i] = d[8*i +: 8];
      end else begin
        compared++; if (capAraddr !== (a & ~32'h3)) begin mismatched++; $display("[TB] FAIL rand%0d araddr: got %h required %h", t, capAraddr, a & ~32'h3); end
        compared++; if (q !== expDout) begin mismatched++; $display("[TB] FAIL rand%0d dout: got %h required %h", t, q, expDout); end
      end
    end
    compared++; if (protoErr !== 0) begin mismatched++; $display("[TB] FAIL random stability: got %0d violations required 0", protoErr); end
  endtask

  // Scenario sequence, then the one-line summary.
  initial begin
    $display("[TB] starting mem_sram_axi_master bench");
    test_reset();
    test_word_write();
    test_byte_write();
    test_half_read();
    test_backpressure();
    test_misaligned();
    test_resp_err();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
